// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the round-robin register write arbiter.
package reg_write_arbiter_pkg;

   // FSM state encoding
   localparam logic ARB_IDLE  = 1'b0;
   localparam logic ARB_GRANT = 1'b1;

   // Default register word width
   localparam int WORD_W = 32'd8;

   typedef enum logic {
      S_IDLE  = ARB_IDLE,
      S_GRANT = ARB_GRANT
   } arb_state_e;

endpackage

// File: rtl/Register.sv
// Single WIDTH-bit storage register with write enable and async active-high reset.
module Register #(
   parameter int WIDTH = 32'd8
) (
   input  logic [WIDTH-1:0] i_D,
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_we,
   output logic [WIDTH-1:0] or_Q
);

   // Capture i_D on a write-enabled rising edge; clear on reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         or_Q <= '0;
      end else if (i_we) begin
         or_Q <= i_D;
      end else begin
         or_Q <= or_Q;
      end
   end

endmodule

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module reg_write_arbiter_rr_pick #(
   parameter int NREQ  = 32'd4,
   parameter int IDX_W = (NREQ > 32'd1) ? $clog2(NREQ) : 32'd1
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [NREQ-1:0]  pick_o,
   output logic [IDX_W-1:0] idx_o
);

   logic found_s;
   int   cand_s;

   // Scan requesters starting at the pointer; the first hit wins, zero pick when idle.
   always_comb begin
      pick_o  = '0;
      idx_o   = '0;
      found_s = 1'b0;
      cand_s  = 32'd0;
      for (int k = 0; k < NREQ; k++) begin
         cand_s = (int'(ptr_i) + k) % NREQ;
         if (!found_s && req_i[cand_s]) begin
            pick_o[cand_s] = 1'b1;
            idx_o          = IDX_W'(cand_s);
            found_s        = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one write at a time into a small register bank,
// with a combinational read port.
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int WIDTH  = WORD_W,
   parameter int NREQ   = 32'd4,
   parameter int NREG   = 32'd4,
   parameter int ADDR_W = 32'd2
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [NREQ-1:0]        i_req,
   input  logic [NREQ*ADDR_W-1:0] i_addr,
   input  logic [NREQ*WIDTH-1:0]  i_data,
   output logic [NREQ-1:0]        or_gnt,
   output logic                   or_busy,
   input  logic [ADDR_W-1:0]      i_rd_addr,
   output logic [WIDTH-1:0]       o_rd_data
);

   localparam int IDX_W = (NREQ > 32'd1) ? $clog2(NREQ) : 32'd1;

   arb_state_e        state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              busy_q, busy_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;

   logic [NREQ-1:0]   pick_s;
   logic [IDX_W-1:0]  idx_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [WIDTH-1:0]  sel_data_s;
   logic              bank_rst_s;
   logic [WIDTH-1:0]  bank_s [NREG];
   logic [WIDTH-1:0]  rd_data_s;

   reg_write_arbiter_rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req_i  (i_req),
      .ptr_i  (ptr_q),
      .pick_o (pick_s),
      .idx_o  (idx_s)
   );

   assign sel_addr_s = i_addr[int'(idx_s)*ADDR_W +: ADDR_W];
   assign sel_data_s = i_data[int'(idx_s)*WIDTH +: WIDTH];

   // Next-state logic: arbitrate in IDLE, spend exactly one cycle in GRANT while the bank writes.
   always_comb begin
      state_d = state_q;
      gnt_d   = '0;
      busy_d  = 1'b0;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      ptr_d   = ptr_q;
      case (state_q)
         S_IDLE: begin
            if (|i_req) begin
               state_d = S_GRANT;
               gnt_d   = pick_s;
               busy_d  = 1'b1;
               addr_d  = sel_addr_s;
               data_d  = sel_data_s;
               // Out-of-range targets still get a grant but never touch the bank.
               we_d    = (int'(sel_addr_s) < NREG);
               ptr_d   = (int'(idx_s) == NREQ - 32'd1) ? '0 : idx_s + IDX_W'(1'b1);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GRANT: begin
            // Requests are ignored here; the earliest next grant is one cycle later.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Arbiter state and write-staging registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bank_rst_s = ~i_rst_n;

   for (genvar g = 0; g < NREG; g++) begin : g_bank
      Register #(
         .WIDTH (WIDTH)
      ) u_reg (
         .i_D   (data_q),
         .i_clk (i_clk),
         .i_rst (bank_rst_s),
         .i_we  (we_q && (addr_q == ADDR_W'(g))),
         .or_Q  (bank_s[g])
      );
   end

   // Read mux; addresses with no backing register read as zero.
   always_comb begin
      rd_data_s = '0;
      for (int r = 0; r < NREG; r++) begin
         if (i_rd_addr == ADDR_W'(r)) begin
            rd_data_s = bank_s[r];
         end else begin
            rd_data_s = rd_data_s;
         end
      end
   end

   assign or_gnt    = gnt_q;
   assign or_busy   = busy_q;
   assign o_rd_data = rd_data_s;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter and its round-robin picker.
module tb_reg_write_arbiter;

   logic        clk;
   logic        rst_n;

   // DUT 0: default parameters (NREG = 4)
   logic [3:0]  req0;
   logic [7:0]  addr0;
   logic [31:0] data0;
   logic [3:0]  gnt0;
   logic        busy0;
   logic [1:0]  rd_a0;
   logic [7:0]  rd_d0;

   // DUT 1: NREG = 3, for out-of-range behaviour
   logic [3:0]  req1;
   logic [7:0]  addr1;
   logic [31:0] data1;
   logic [3:0]  gnt1;
   logic        busy1;
   logic [1:0]  rd_a1;
   logic [7:0]  rd_d1;

   // Standalone picker
   logic [3:0]  pk_req;
   logic [1:0]  pk_ptr;
   logic [3:0]  pk_pick;
   logic [1:0]  pk_idx;

   int pass_cnt  = 0;
   int total_cnt = 0;

   reg_write_arbiter #(.WIDTH(8), .NREQ(4), .NREG(4), .ADDR_W(2)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req0), .i_addr(addr0), .i_data(data0),
      .or_gnt(gnt0), .or_busy(busy0), .i_rd_addr(rd_a0), .o_rd_data(rd_d0)
   );

   reg_write_arbiter #(.WIDTH(8), .NREQ(4), .NREG(3), .ADDR_W(2)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req1), .i_addr(addr1), .i_data(data1),
      .or_gnt(gnt1), .or_busy(busy1), .i_rd_addr(rd_a1), .o_rd_data(rd_d1)
   );

   reg_write_arbiter_rr_pick #(.NREQ(4), .IDX_W(2)) u_pick (
      .req_i(pk_req), .ptr_i(pk_ptr), .pick_o(pk_pick), .idx_o(pk_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic [1:0] ptr;
      logic [3:0] exp_pick;
      logic [1:0] exp_idx;
   } pick_vec_t;

   pick_vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set0(input int j, input logic [1:0] a, input logic [7:0] d);
      addr0[j*2 +: 2] = a;
      data0[j*8 +: 8] = d;
   endtask

   task automatic set1(input int j, input logic [1:0] a, input logic [7:0] d);
      addr1[j*2 +: 2] = a;
      data1[j*8 +: 8] = d;
   endtask

   task automatic rd0(input logic [1:0] a, input logic [7:0] exp, input string name);
      rd_a0 = a;
      #1;
      chk(name, {24'd0, rd_d0}, {24'd0, exp});
   endtask

   task automatic rd1(input logic [1:0] a, input logic [7:0] exp, input string name);
      rd_a1 = a;
      #1;
      chk(name, {24'd0, rd_d1}, {24'd0, exp});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req0  = 4'd0;
      req1  = 4'd0;
      cyc();
      rst_n = 1'b1;
   endtask

   // Reference model state
   int         m_ptr;
   logic [3:0] m_gnt;
   bit         m_busy;
   int         m_addr;
   logic [7:0] m_data;
   logic [7:0] m_bank [4];
   int         mj;

   logic [3:0] cexp [4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      req0 = 4'd0; addr0 = 8'd0; data0 = 32'd0; rd_a0 = 2'd0;
      req1 = 4'd0; addr1 = 8'd0; data1 = 32'd0; rd_a1 = 2'd0;
      pk_req = 4'd0; pk_ptr = 2'd0;

      // ---------------- picker table ----------------
      tbl[0] = '{4'b0000, 2'd0, 4'b0000, 2'd0};
      tbl[1] = '{4'b0001, 2'd0, 4'b0001, 2'd0};
      tbl[2] = '{4'b0110, 2'd0, 4'b0010, 2'd1};
      tbl[3] = '{4'b0110, 2'd2, 4'b0100, 2'd2};
      tbl[4] = '{4'b0110, 2'd3, 4'b0010, 2'd1};
      tbl[5] = '{4'b1001, 2'd1, 4'b1000, 2'd3};
      tbl[6] = '{4'b1001, 2'd3, 4'b1000, 2'd3};
      tbl[7] = '{4'b1111, 2'd2, 4'b0100, 2'd2};
      tbl[8] = '{4'b1000, 2'd0, 4'b1000, 2'd3};
      tbl[9] = '{4'b0001, 2'd3, 4'b0001, 2'd0};
      for (int i = 0; i < 10; i++) begin
         pk_req = tbl[i].req;
         pk_ptr = tbl[i].ptr;
         #1;
         chk($sformatf("pick_onehot[%0d]", i), {28'd0, pk_pick}, {28'd0, tbl[i].exp_pick});
         if (tbl[i].exp_pick != 4'd0)
            chk($sformatf("pick_idx[%0d]", i), {30'd0, pk_idx}, {30'd0, tbl[i].exp_idx});
      end

      // ---------------- reset with random requests ----------------
      @(negedge clk);
      req0 = 4'($urandom) | 4'b0001;
      req1 = 4'($urandom) | 4'b0010;
      cyc();
      cyc();
      chk("reset_gnt", {28'd0, gnt0}, 32'd0);
      chk("reset_busy", {31'd0, busy0}, 32'd0);
      for (int a = 0; a < 4; a++) rd0(2'(a), 8'h00, $sformatf("reset_rd%0d", a));
      req0 = 4'd0;
      req1 = 4'd0;
      rst_n = 1'b1;

      // ---------------- single write ----------------
      set0(1, 2'd2, 8'hA5);
      req0 = 4'b0010;
      cyc();
      chk("single_gnt", {28'd0, gnt0}, 32'h2);
      chk("single_busy", {31'd0, busy0}, 32'd1);
      req0 = 4'd0;
      cyc();
      chk("single_gnt_drop", {28'd0, gnt0}, 32'd0);
      chk("single_busy_drop", {31'd0, busy0}, 32'd0);
      rd0(2'd2, 8'hA5, "single_rd2");
      rd0(2'd0, 8'h00, "single_rd0");
      rd0(2'd1, 8'h00, "single_rd1");
      rd0(2'd3, 8'h00, "single_rd3");

      // ---------------- contention ----------------
      do_reset();
      set0(0, 2'd0, 8'h11);
      set0(2, 2'd1, 8'h22);
      req0 = 4'b0101;
      cexp[0] = 4'b0001; cexp[1] = 4'b0100; cexp[2] = 4'b0001; cexp[3] = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk($sformatf("contend_gnt%0d", i), {28'd0, gnt0}, {28'd0, cexp[i]});
         cyc();
         chk($sformatf("contend_gap%0d", i), {28'd0, gnt0}, 32'd0);
      end
      req0 = 4'd0;
      rd0(2'd0, 8'h11, "contend_rd0");
      rd0(2'd1, 8'h22, "contend_rd1");

      // ---------------- pointer wrap (pointer is now 3) ----------------
      set0(3, 2'd3, 8'h33);
      req0 = 4'b1000;
      cyc();
      chk("wrap_first", {28'd0, gnt0}, 32'h8);
      req0 = 4'b1001;
      cyc();
      chk("wrap_ignored", {28'd0, gnt0}, 32'd0);
      cyc();
      chk("wrap_next", {28'd0, gnt0}, 32'h1);
      req0 = 4'd0;
      cyc();
      rd0(2'd3, 8'h33, "wrap_rd3");

      // ---------------- reset mid-grant ----------------
      set0(3, 2'd3, 8'h7E);
      req0 = 4'b1000;
      @(posedge clk);
      #1;
      chk("midrst_gnt_up", {28'd0, gnt0}, 32'h8);
      rst_n = 1'b0;
      #1;
      chk("midrst_gnt", {28'd0, gnt0}, 32'd0);
      chk("midrst_busy", {31'd0, busy0}, 32'd0);
      req0 = 4'd0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      rd0(2'd3, 8'h00, "midrst_rd3");

      // ---------------- out of range on NREG=3 ----------------
      set1(1, 2'd1, 8'h5A);
      req1 = 4'b0010;
      cyc();
      chk("oor_pre_gnt", {28'd0, gnt1}, 32'h2);
      req1 = 4'd0;
      cyc();
      set1(0, 2'd3, 8'hFF);
      req1 = 4'b0001;
      cyc();
      chk("oor_gnt", {28'd0, gnt1}, 32'h1);
      chk("oor_busy", {31'd0, busy1}, 32'd1);
      req1 = 4'd0;
      cyc();
      chk("oor_gnt_drop", {28'd0, gnt1}, 32'd0);
      rd1(2'd0, 8'h00, "oor_rd0");
      rd1(2'd1, 8'h5A, "oor_rd1");
      rd1(2'd2, 8'h00, "oor_rd2");
      rd1(2'd3, 8'h00, "oor_rd3");

      // ---------------- randomized run against reference model ----------------
      do_reset();
      m_ptr = 0; m_gnt = 4'd0; m_busy = 1'b0; m_addr = 0; m_data = 8'd0;
      for (int a = 0; a < 4; a++) m_bank[a] = 8'd0;
      for (int n = 0; n < 500; n++) begin
         req0  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
         addr0 = 8'($urandom);
         data0 = $urandom;
         rd_a0 = 2'($urandom);
         @(posedge clk);
         if (m_busy) begin
            if (m_addr < 4) m_bank[m_addr] = m_data;
            m_busy = 1'b0;
            m_gnt  = 4'd0;
         end else begin
            m_gnt = 4'd0;
            for (int k = 0; k < 4; k++) begin
               mj = (m_ptr + k) % 4;
               if (m_gnt == 4'd0 && req0[mj]) begin
                  m_gnt  = 4'b0001 << mj;
                  m_busy = 1'b1;
                  m_addr = int'(addr0[mj*2 +: 2]);
                  m_data = data0[mj*8 +: 8];
                  m_ptr  = (mj + 1) % 4;
               end
            end
         end
         @(negedge clk);
         chk($sformatf("rand_gnt@%0d", n), {28'd0, gnt0}, {28'd0, m_gnt});
         chk($sformatf("rand_busy@%0d", n), {31'd0, busy0}, {31'd0, m_busy});
         chk($sformatf("rand_rd@%0d", n), {24'd0, rd_d0}, {24'd0, m_bank[rd_a0]});
      end
      req0 = 4'd0;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
